// File: rtl/pattern_detector.sv
// Serial bit-pattern detector.
// A programmable pattern of up to MAX_LEN bits is matched against a stream of
// valid-qualified serial bits. Matches may overlap or not, are reported as a
// registered one-cycle pulse, and are tallied in a saturating counter.
module pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Lengths above MAX_LEN are treated as MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > MAX_LEN_L) begin
      return MAX_LEN_L;
    end else begin
      return l;
    end
  endfunction

  // Mask with the low l bits set; selects the compared part of the history.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (LEN_W'(i) < l);
    end
    return m;
  endfunction

  // Active configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;

  // Stream state
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  state_t             state_r;
  state_t             state_s;

  // Output registers
  logic               match_r;
  logic [CNT_W-1:0]   count_r;

  // Combinational helpers
  logic               shift_s;
  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               hit_s;
  logic               restart_s;

  // A bit is accepted only when valid, not clobbered by a config load, and a
  // pattern is configured (IDLE ignores the stream entirely).
  always_comb begin
    shift_s      = din_valid && !cfg_load && (state_r != IDLE);
    hist_shift_s = {hist_r[MAX_LEN-2:0], din};
    mask_s       = len_mask(len_r);
    if (fill_r >= len_r) begin
      fill_inc_s = len_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
    hit_s     = shift_s && (fill_inc_s >= len_r) &&
                ((hist_shift_s & mask_s) == (pat_r & mask_s));
    restart_s = hit_s && !ovl_r;
  end

  // Next-state logic: config loads override everything, otherwise the fill
  // level drives FILL/ARMED and a non-overlapping match restarts filling.
  always_comb begin
    state_s = state_r;
    if (cfg_load) begin
      if (clamp_len(cfg_len) == LEN_W'(0)) begin
        state_s = IDLE;
      end else begin
        state_s = FILL;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        FILL: begin
          if (shift_s && (fill_inc_s == len_r) && !restart_s) begin
            state_s = ARMED;
          end else begin
            state_s = FILL;
          end
        end
        ARMED: begin
          if (restart_s) begin
            state_s = FILL;
          end else begin
            state_s = ARMED;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Configuration registers, written only on cfg_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r <= '0;
      len_r <= '0;
      ovl_r <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= clamp_len(cfg_len);
      ovl_r <= cfg_overlap;
    end else begin
      pat_r <= pat_r;
      len_r <= len_r;
      ovl_r <= ovl_r;
    end
  end

  // History shift register and fill level; a load starts from scratch and a
  // non-overlapping match forces len fresh bits before the next match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (cfg_load) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (shift_s) begin
      hist_r <= hist_shift_s;
      if (restart_s) begin
        fill_r <= '0;
      end else begin
        fill_r <= fill_inc_s;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Registered match pulse, one cycle after the completing bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_r <= 1'b0;
    end else begin
      match_r <= hit_s;
    end
  end

  // Saturating match counter; a clear wins over a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (cnt_clr) begin
      count_r <= '0;
    end else if (hit_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign match       = match_r;
  assign match_count = count_r;
  assign armed       = (state_r == ARMED);

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector (MAX_LEN=8, CNT_W=2).
// Each step pushes its expected {match, match_count, armed} onto a scoreboard
// queue; after the clock edge the entry is popped and compared.
module tb_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din;
  logic               din_valid;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  typedef struct {
    logic             m;
    logic [CNT_W-1:0] c;
    logic             a;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din         (din),
    .din_valid   (din_valid),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic em, input logic [CNT_W-1:0] ec,
                          input logic ea, input string tag);
    exp_t e;
    e.m = em; e.c = ec; e.a = ea; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      total++;
      assert (match === e.m) else begin
        bad++;
        $error("FAIL %s match got=%b exp=%b", e.tag, match, e.m);
      end
      total++;
      assert (match_count === e.c) else begin
        bad++;
        $error("FAIL %s match_count got=%0d exp=%0d", e.tag, match_count, e.c);
      end
      total++;
      assert (armed === e.a) else begin
        bad++;
        $error("FAIL %s armed got=%b exp=%b", e.tag, armed, e.a);
      end
    end
  endtask

  task automatic step(input logic b, input logic v, input logic clr,
                      input logic em, input logic [CNT_W-1:0] ec,
                      input logic ea, input string tag);
    cfg_load  = 1'b0;
    din       = b;
    din_valid = v;
    cnt_clr   = clr;
    push_exp(em, ec, ea, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic b, input logic v,
                      input logic [CNT_W-1:0] ec, input string tag);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    din         = b;
    din_valid   = v;
    cnt_clr     = 1'b0;
    push_exp(1'b0, ec, 1'b0, tag);
    @(posedge clk);
    #1;
    check_out();
    cfg_load = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, 2'd0, 1'b0, "reset_state");
    check_out();
    reset = 1'b0;

    // Idle after reset: valid bits are ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "idle_bit");

    // 11010, len 5, non-overlap; load-cycle bit is not valid here
    load(8'b0001_1010, 4'd5, 1'b0, 1'b1, 1'b0, 2'd0, "s34_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s34_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s34_b2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s34_b3");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s34_b4");
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, "s34_b5");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, "s34_after");

    // 101, len 3, overlap, with a valid gap inside the partial match
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "s35_clr");
    load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0, "s35_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s35_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "s35_gap");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s35_b2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, "s35_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "s35_b4");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, "s35_b5");

    // Same stream, non-overlap: armed drops for two bits
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, "s36_clr");
    load(8'b0000_0101, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0, "s36_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s36_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s36_b2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, "s36_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s36_b4");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s36_b5");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "s36_b6");

    // Saturation of the 2-bit counter, then clear against a match
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, "s37_clr");
    load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0, "s37_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s37_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s37_b2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, "s37_m1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, "s37_z1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, "s37_m2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, "s37_z2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "s37_m3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, "s37_z3");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "s37_m4");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, "s37_z4");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "s37_m5");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, "s37_z5");
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, "s37_clr_win");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, "s37_z6");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, "s37_m6");

    // Reset mid-sequence discards the partial match
    load(8'b0001_1010, 4'd5, 1'b0, 1'b0, 1'b0, 2'd1, "s38_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s38_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s38_b2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s38_b3");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s38_b4");
    @(negedge clk);
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    #1;
    push_exp(1'b0, 2'd0, 1'b0, "s38_async_rst");
    check_out();
    @(posedge clk);
    #1;
    push_exp(1'b0, 2'd0, 1'b0, "s38_in_rst");
    check_out();
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s38_idle");
    load(8'b0001_1010, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0, "s38_reload");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s38_b5");

    // Length clamp: 12 -> 8, load-cycle bit discarded
    load(8'hA5, 4'd12, 1'b0, 1'b1, 1'b1, 2'd0, "s39_load");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b4");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b5");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b6");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "s39_b7");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, "s39_b8");

    // len=0 returns to IDLE: nothing ever matches
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 2'd1, "s39_len0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s39_i1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s39_i2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s39_i3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "s39_i4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
